tick_generator: RTL and testbench
=================================

// Module: tick_generator
// PURPOSE
//  Parametrised successor to the free-running divider: keeps the WIDTH-bit free-running
//  count bus and adds NUM_CH independently programmable channels. Each channel emits a
//  1-cycle tick strobe every DIV cycles plus a toggled square wave of period 2*DIV.
//  Sits at top level beside the system clock and feeds slow-rate enables (display scan,
//  debounce, audio/sample strobes) without creating derived clock domains.
// PARAMETERS
//  WIDTH        32  width of free-running count bus divided_clocks
//  NUM_CH       4   number of programmable channels (>=1)
//  DIV_W        24  width of each channel divisor
//  DEFAULT_DIV  0   divisor loaded into every channel at reset (0 = channel off)
//  CH_W         derived: max(1, clog2(NUM_CH)); not overridable
// PORTS
//  clk            in   1             system clock; all logic on posedge clk
//  reset          in   1             synchronous, active-high reset
//  enable         in   1             global run; 0 freezes all channels
//  cfg_we         in   1             config write strobe, one cycle
//  cfg_ch         in   CH_W          channel index for write
//  cfg_div        in   DIV_W         new divisor for cfg_ch
//  divided_clocks out  WIDTH         free-running count
//  ch_tick        out  NUM_CH        per-channel 1-cycle strobe
//  ch_clk         out  NUM_CH        per-channel square wave (toggles on each tick)
//  ch_active      out  NUM_CH        1 when channel divisor != 0
// BEHAVIOUR
//  - Reset (sync, active-high): divided_clocks=0, cnt=0, div=DEFAULT_DIV, pend_valid=0,
//    ch_tick=0, ch_clk=0, ch_active=(DEFAULT_DIV!=0). Reset overrides cfg_we and enable.
//  - divided_clocks: +1 every cycle out of reset, independent of enable; wraps 2^WIDTH-1 -> 0.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - Per channel, cycle with enable=1 and div!=0:
//      cnt==div-1: cnt<=0, ch_tick<=1, ch_clk<=~ch_clk ("wrap"); else cnt<=cnt+1, ch_tick<=0.
//    => first tick asserts DIV cycles after reset release; then every DIV cycles.
//    div=1: ch_tick constant 1, ch_clk toggles every cycle (period 2).
//  - enable=0: cnt and ch_clk hold, ch_tick<=0; config writes still accepted.
//  - div==0 (off): cnt=0, ch_tick=0, ch_clk=0, ch_active=0.
//  - Config write (cfg_we=1, cfg_ch<NUM_CH):
//      channel off: div<=cfg_div, cnt<=0 next cycle (immediate start, phase from zero).
//      channel running: pend_div<=cfg_div, pend_valid<=1; applied at next wrap
//        (div<=pend_div, pend_valid<=0) -> no runt/glitched period.
//      write in same cycle as a wrap: written value applied at that wrap (forwarded).
//      second write before wrap: last write wins.
//      applied divisor 0: at that wrap ch_tick=1 (final tick), then ch_clk<=0, channel off.
//  - cfg_ch>=NUM_CH: write ignored, no state change.
//  - Arithmetic: cnt is DIV_W bits; compare against div-1 only when div!=0 (no underflow).
// STRUCTURE
//  - Shared package tick_gen_pkg: DIV_W default, clog2 helper/CH_W rule, DIV_OFF=0 constant.
//  - Sub-module tick_channel (one per channel, generate loop): cnt, div, pend_div,
//    pend_valid, tick/clk/active registers; ports clk, reset, enable, wr, wr_div, tick,
//    sq, active. Top holds free-running counter and cfg_ch decode only.
// TESTING
//  1 reset held 3 cycles, DEFAULT_DIV=0 -> all outputs 0; divided_clocks 0,1,2.. after release.
//  2 write ch0 div=4 while off -> ch_tick[0] high every 4th cycle, ch_clk[0] period 8, 50% duty.
//  3 ch1 running div=5, write div=3 mid-period -> current period completes at 5, then period 3.
//  4 div=6 running, drop enable for 10 cycles mid-count -> tick spacing = 6 enabled cycles,
//    ch_tick never high while enable=0, ch_clk held.
//  5 write div=0 to running ch2 (div=4) -> one final tick at wrap, then ch_clk=0, ch_active=0;
//    write to cfg_ch=NUM_CH (NUM_CH=3 build) -> no channel changes.
//  6 WIDTH=4: divided_clocks wraps 15->0; assert reset mid-period -> cnt=0, ticks restart
//    DIV cycles after release, pending write discarded.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick generator and its channels.
package tick_gen_pkg;

    localparam int DIV_W_DEFAULT = 24;
    localparam int DIV_OFF       = 0;

    // Channel-select width: enough bits to index NUM_CH channels, never below one.
    function automatic int ch_width(input int num_ch);
        int w;
        if (num_ch <= 1) begin
            w = 1;
        end else begin
            w = $clog2(num_ch);
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable divider channel: tick strobe, square wave and glitch-free divisor updates.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             active
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] OFF_DIV   = DIV_W'(DIV_OFF);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             active_q, active_d;
    logic             running_s;
    logic             wrap_s;

    // Next-state logic for counter, divisor hand-over and outputs.
    always_comb begin
        cnt_d        = cnt_q;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        sq_d         = sq_q;
        running_s    = (div_q != OFF_DIV);
        wrap_s       = 1'b0;

        if (running_s && enable) begin
            wrap_s = (cnt_q == (div_q - DIV_W'(1)));
        end else begin
            wrap_s = 1'b0;
        end

        if (!running_s) begin
            // An idle channel takes a new divisor at once and starts its phase from zero.
            cnt_d        = '0;
            sq_d         = 1'b0;
            pend_valid_d = 1'b0;
            if (wr) begin
                div_d = wr_div;
            end else begin
                div_d = div_q;
            end
        end else begin
            if (wr) begin
                pend_div_d   = wr_div;
                pend_valid_d = 1'b1;
            end else begin
                pend_div_d   = pend_div_q;
                pend_valid_d = pend_valid_q;
            end

            if (wrap_s) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                // A write landing on the wrap itself is forwarded so it is not lost a period.
                if (wr) begin
                    div_d        = wr_div;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    div_d        = pend_div_q;
                    pend_valid_d = 1'b0;
                end else begin
                    div_d = div_q;
                end
                if (div_d == OFF_DIV) begin
                    sq_d = 1'b0;
                end else begin
                    sq_d = ~sq_q;
                end
            end else if (enable) begin
                cnt_d = cnt_q + DIV_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        active_d = (div_d != OFF_DIV);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            div_q        <= RESET_DIV;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            sq_q         <= 1'b0;
            active_q     <= (RESET_DIV != OFF_DIV);
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            sq_q         <= sq_d;
            active_q     <= active_d;
        end
    end

    assign tick   = tick_q;
    assign sq     = sq_q;
    assign active = active_q;

endmodule

// File: rtl/tick_generator.sv
// Free-running count bus plus NUM_CH programmable tick/square-wave channels.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cfg_we,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic [WIDTH-1:0]            divided_clocks,
    output logic [NUM_CH-1:0]           ch_tick,
    output logic [NUM_CH-1:0]           ch_clk,
    output logic [NUM_CH-1:0]           ch_active
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [WIDTH-1:0] divided_clocks_q, divided_clocks_d;

    // Free-running count, independent of enable.
    always_comb begin
        divided_clocks_d = divided_clocks_q + WIDTH'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            divided_clocks_q <= '0;
        end else begin
            divided_clocks_q <= divided_clocks_d;
        end
    end

    assign divided_clocks = divided_clocks_q;

    // Out-of-range channel indices match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_s;
        assign wr_s = cfg_we && (cfg_ch == CH_W'(i));

        tick_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .wr     (wr_s),
            .wr_div (cfg_div),
            .tick   (ch_tick[i]),
            .sq     (ch_clk[i]),
            .active (ch_active[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench: vector table for reset/first channel, hand sequences for multi-cycle corners.
module tb_tick_generator;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, NUM_CH=3, all channels off at reset
    logic          reset_a, enable_a, we_a;
    logic [1:0]    ch_a;
    logic [DW-1:0] div_a;
    logic [3:0]    dc_a;
    logic [2:0]    tick_a, sq_a, act_a;

    // Instance B: WIDTH=4, NUM_CH=1, DEFAULT_DIV=5
    logic          reset_b, enable_b, we_b;
    logic [0:0]    ch_b;
    logic [DW-1:0] div_b;
    logic [3:0]    dc_b;
    logic [0:0]    tick_b, sq_b, act_b;

    tick_generator #(.WIDTH(4), .NUM_CH(3), .DIV_W(DW), .DEFAULT_DIV(0)) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .cfg_we(we_a), .cfg_ch(ch_a),
        .cfg_div(div_a), .divided_clocks(dc_a), .ch_tick(tick_a), .ch_clk(sq_a),
        .ch_active(act_a)
    );

    tick_generator #(.WIDTH(4), .NUM_CH(1), .DIV_W(DW), .DEFAULT_DIV(5)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .cfg_we(we_b), .cfg_ch(ch_b),
        .cfg_div(div_b), .divided_clocks(dc_b), .ch_tick(tick_b), .ch_clk(sq_b),
        .ch_active(act_b)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_dc_a = 4'd0;
    logic [3:0] exp_dc_b = 4'd0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [2:0] tick;
        logic [2:0] sq;
        logic [2:0] act;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge; count bus of both instances checked against a wrap-at-16 model.
    task automatic step();
        exp_dc_a = reset_a ? 4'd0 : exp_dc_a + 4'd1;
        exp_dc_b = reset_b ? 4'd0 : exp_dc_b + 4'd1;
        @(posedge clk);
        #1;
        chk("dc_a", dc_a, exp_dc_a);
        chk("dc_b", dc_b, exp_dc_b);
    endtask

    initial begin
        logic exp_t;
        int   nticks;

        reset_a = 1'b1; enable_a = 1'b1; we_a = 1'b0; ch_a = 2'd0; div_a = 8'd0;
        reset_b = 1'b1; enable_b = 1'b1; we_b = 1'b0; ch_b = 1'b0; div_b = 8'd0;

        // Reset 3 cycles, then ch0 div=4 written while off: tick every 4th, sq period 8
        vt[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd4, 3'b000, 3'b000, 3'b001};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b001};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 3'b001};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 3'b001};
        vt[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b001, 3'b001};
        vt[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b001};
        vt[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b001};
        vt[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 3'b001, 3'b001, 3'b001};

        for (int i = 0; i < 16; i++) begin
            reset_a = vt[i].rst; enable_a = vt[i].en; we_a = vt[i].we;
            ch_a = vt[i].ch; div_a = vt[i].div;
            reset_b = 1'b0;
            step();
            chk("tbl_tick", tick_a, vt[i].tick);
            chk("tbl_sq", sq_a, vt[i].sq);
            chk("tbl_active", act_a, vt[i].act);
        end

        // Reset wins over a simultaneous config write
        reset_a = 1'b1; we_a = 1'b1; ch_a = 2'd0; div_a = 8'd3;
        step();
        chk("rst_over_we_active", act_a, 3'b000);
        chk("rst_over_we_tick", tick_a, 3'b000);
        chk("rst_over_we_sq", sq_a, 3'b000);

        // ch1 div=5, mid-period 3, last-write-wins (9 then 4), write forwarded at wrap (2)
        reset_a = 1'b0; we_a = 1'b1; ch_a = 2'd1; div_a = 8'd5;
        step();
        chk("t3_active", act_a[1], 1'b1);
        nticks = 0;
        for (int k = 1; k <= 17; k++) begin
            we_a = 1'b1; ch_a = 2'd1;
            case (k)
                3:       div_a = 8'd3;
                6:       div_a = 8'd9;
                7:       div_a = 8'd4;
                12:      div_a = 8'd2;
                default: we_a = 1'b0;
            endcase
            step();
            exp_t = (k == 5 || k == 8 || k == 12 || k == 14 || k == 16);
            if (exp_t) nticks++;
            chk("t3_tick", tick_a[1], exp_t);
            chk("t3_sq", sq_a[1], nticks[0]);
        end
        we_a = 1'b0;

        // ch0 div=6, enable dropped for 10 edges mid-count
        reset_a = 1'b1;
        step();
        reset_a = 1'b0; we_a = 1'b1; ch_a = 2'd0; div_a = 8'd6;
        step();
        we_a = 1'b0;
        nticks = 0;
        for (int k = 1; k <= 29; k++) begin
            enable_a = !(k >= 9 && k <= 18);
            step();
            exp_t = (k == 6 || k == 22 || k == 28);
            if (exp_t) nticks++;
            chk("t4_tick", tick_a[0], exp_t);
            chk("t4_sq", sq_a[0], nticks[0]);
        end
        enable_a = 1'b1;

        // ch2 div=4, write div=0 while running: one final tick, then off
        reset_a = 1'b1;
        step();
        reset_a = 1'b0; we_a = 1'b1; ch_a = 2'd2; div_a = 8'd4;
        step();
        nticks = 0;
        for (int k = 1; k <= 11; k++) begin
            we_a = (k == 5); ch_a = 2'd2; div_a = 8'd0;
            step();
            exp_t = (k == 4 || k == 8);
            if (exp_t) nticks++;
            chk("t5_tick", tick_a[2], exp_t);
            chk("t5_sq", sq_a[2], nticks[0]);
            if (k < 8) chk("t5_active_on", act_a[2], 1'b1);
            else if (k > 8) chk("t5_active_off", act_a[2], 1'b0);
        end

        // Write to cfg_ch=3 on a 3-channel build changes nothing
        we_a = 1'b1; ch_a = 2'd3; div_a = 8'd2;
        step();
        we_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_bad_ch_active", act_a, 3'b000);
            chk("t5_bad_ch_tick", tick_a, 3'b000);
        end

        // Instance B: DEFAULT_DIV=5, reset mid-period discards a pending write
        reset_b = 1'b1; we_b = 1'b1; ch_b = 1'b0; div_b = 8'd2;
        step();
        chk("t6_reset_active", act_b, 1'b1);
        chk("t6_reset_tick", tick_b, 1'b0);
        we_b = 1'b0; reset_b = 1'b0;
        nticks = 0;
        for (int k = 1; k <= 23; k++) begin
            we_b = (k == 11); div_b = 8'd2;
            reset_b = (k == 12);
            step();
            exp_t = (k == 5 || k == 10 || k == 17 || k == 22);
            if (k == 12) nticks = 0;
            if (exp_t) nticks++;
            chk("t6_tick", tick_b, exp_t);
            chk("t6_sq", sq_b, nticks[0]);
            chk("t6_active", act_b, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
